rng_postproc: RTL and testbench

Downstream conditioning stage for the ring-oscillator TRNG bit source. It consumes the registered raw bit stream, discards a start-up window and runs a repetition-count health test on the raw samples. Surviving entropy is debiased with a von Neumann extractor and packed into WORD_W-bit words, which are delivered over a valid/ready handshake to the key/seed consumer.

---
 rtl/rng_postproc.sv | 138 +++++++++++++
 tb/tb_rng_postproc.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rng_postproc.sv
// Conditioning stage for the ring-oscillator TRNG: start-up discard, repetition-count
// health test, von Neumann debiasing and word packing behind a valid/ready handshake.
module rng_postproc #(
    parameter int WORD_W          = 8,
    parameter int RCT_CUTOFF      = 32,
    parameter int STARTUP_DISCARD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              raw_bit,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              health_fail
);
    localparam int DW = $clog2(STARTUP_DISCARD + 2);
    localparam int RW = $clog2(RCT_CUTOFF + 1);
    localparam int AW = $clog2(WORD_W + 1);
    localparam logic [DW-1:0] DISC_MAX = DW'(STARTUP_DISCARD);
    localparam logic [RW-1:0] RCT_MAX  = RW'(RCT_CUTOFF);
    localparam logic [AW-1:0] ASM_FULL = AW'(WORD_W);

    typedef enum logic {PAIR_FIRST, PAIR_SECOND} pair_e;

    pair_e             pair_q, pair_d;
    logic [DW-1:0]     disc_cnt_q, disc_cnt_d;
    logic [RW-1:0]     rep_cnt_q, rep_cnt_d;
    logic              prev_q, prev_d;
    logic              b0_q, b0_d;
    logic              health_fail_q, health_fail_d;
    logic [AW-1:0]     acnt_q, acnt_d;
    logic [WORD_W-1:0] asm_q, asm_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              valid_q, valid_d;

    logic sample, bit_vld, fail_now, xfer, full;

    always_comb begin
        // NOTE: every variable gets its hold value first, so no branch can leave one unassigned and infer a latch.
        pair_d        = pair_q;
        disc_cnt_d    = disc_cnt_q;
        rep_cnt_d     = rep_cnt_q;
        prev_d        = prev_q;
        b0_d          = b0_q;
        health_fail_d = health_fail_q;
        acnt_d        = acnt_q;
        asm_d         = asm_q;
        word_d        = word_q;
        valid_d       = valid_q;
        sample        = 1'b0;
        bit_vld       = 1'b0;
        fail_now      = 1'b0;
        xfer          = valid_q && word_ready;
        full          = (acnt_q == ASM_FULL);

        if (!enable) begin
            disc_cnt_d = '0;
            rep_cnt_d  = '0;
            pair_d     = PAIR_FIRST;
        end else if (disc_cnt_q < DISC_MAX) begin
            disc_cnt_d = disc_cnt_q + DW'(1);
        end else begin
            sample = 1'b1;
        end

        if (sample) begin
            if (rep_cnt_q == '0 || raw_bit != prev_q) begin
                rep_cnt_d = RW'(1);
            end else if (rep_cnt_q != RCT_MAX) begin
                rep_cnt_d = rep_cnt_q + RW'(1);
            end
            prev_d = raw_bit;
            if (rep_cnt_d == RCT_MAX) begin
                fail_now      = 1'b1;
                health_fail_d = 1'b1;
            end
            if (pair_q == PAIR_FIRST) begin
                b0_d   = raw_bit;
                pair_d = PAIR_SECOND;
            end else begin
                pair_d  = PAIR_FIRST;
                bit_vld = (b0_q != raw_bit);
            end
        end

        // A detected failure kills any pending word and stops packing until reset.
        if (xfer) valid_d = 1'b0;
        if (health_fail_q) begin
            valid_d = 1'b0;
            acnt_d  = '0;
        end else begin
            if (full && (!valid_q || xfer)) begin
                word_d  = asm_q;
                valid_d = 1'b1;
                acnt_d  = '0;
            end
            if (!enable) begin
                acnt_d = '0;
            end else if (bit_vld && !fail_now && acnt_d != ASM_FULL) begin
                asm_d  = {asm_q[WORD_W-2:0], b0_q};
                acnt_d = acnt_d + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            pair_q        <= PAIR_FIRST;
            disc_cnt_q    <= '0;
            rep_cnt_q     <= '0;
            prev_q        <= 1'b0;
            b0_q          <= 1'b0;
            health_fail_q <= 1'b0;
            acnt_q        <= '0;
            asm_q         <= '0;
            word_q        <= '0;
            valid_q       <= 1'b0;
        end else begin
            pair_q        <= pair_d;
            disc_cnt_q    <= disc_cnt_d;
            rep_cnt_q     <= rep_cnt_d;
            prev_q        <= prev_d;
            b0_q          <= b0_d;
            health_fail_q <= health_fail_d;
            acnt_q        <= acnt_d;
            asm_q         <= asm_d;
            word_q        <= word_d;
            valid_q       <= valid_d;
        end
    end

    assign word_out    = word_q;
    assign word_valid  = valid_q;
    assign health_fail = health_fail_q;

endmodule

// File: tb/tb_rng_postproc.sv
// Self-checking bench for rng_postproc: a queue-based reference model compared every cycle,
// plus hand-computed literal expectations at the interesting points.
module tb_rng_postproc;
    localparam int W    = 8;
    localparam int CUT  = 32;
    localparam int DISC = 4;

    logic         clk = 1'b0;
    logic         rst_n, enable, raw_bit, word_ready;
    logic [W-1:0] word_out;
    logic         word_valid, health_fail;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    rng_postproc #(.WORD_W(W), .RCT_CUTOFF(CUT), .STARTUP_DISCARD(DISC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .raw_bit    (raw_bit),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .health_fail(health_fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: counts, run length and a queue of extracted bits awaiting packing.
    bit         m_valid = 1'b0;
    bit         m_fail  = 1'b0;
    logic [W-1:0] m_word = '0;
    int         m_disc  = 0;
    int         m_run   = 0;
    int         m_last  = 0;
    int         m_first = -1;
    bit         m_asm[$];

    always @(posedge clk) begin : model
        bit m_xfer, fail_was, fail_now;
        int ext;
        if (!rst_n) begin
            m_valid = 1'b0; m_fail = 1'b0; m_word = '0;
            m_disc = 0; m_run = 0; m_last = 0; m_first = -1;
            m_asm.delete();
        end else begin
            m_xfer   = m_valid && word_ready;
            fail_was = m_fail;
            fail_now = 1'b0;
            ext      = -1;
            if (!enable) begin
                m_disc = 0; m_run = 0; m_first = -1;
            end else if (m_disc < DISC) begin
                m_disc++;
            end else begin
                if (m_run != 0 && int'(raw_bit) == m_last) m_run = m_run + 1;
                else m_run = 1;
                if (m_run > CUT) m_run = CUT;
                m_last = int'(raw_bit);
                if (m_run == CUT) begin fail_now = 1'b1; m_fail = 1'b1; end
                if (m_first < 0) m_first = int'(raw_bit);
                else begin
                    if (m_first != int'(raw_bit)) ext = m_first;
                    m_first = -1;
                end
            end
            if (fail_was) begin
                m_valid = 1'b0;
                m_asm.delete();
            end else begin
                if (m_xfer) m_valid = 1'b0;
                if (m_asm.size() == W && !m_valid) begin
                    m_word = '0;
                    foreach (m_asm[i]) m_word = {m_word[W-2:0], m_asm[i]};
                    m_valid = 1'b1;
                    m_asm.delete();
                end
                if (!enable) m_asm.delete();
                if (ext >= 0 && !fail_now && m_asm.size() < W) m_asm.push_back(ext[0]);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_valid", word_valid, m_valid);
            check("cyc_fail", health_fail, m_fail);
            if (m_valid) check("cyc_word", word_out, m_word);
        end
    end

    task automatic step(input bit en, input bit raw, input bit rdy);
        enable = en; raw_bit = raw; word_ready = rdy;
        @(negedge clk);
    endtask

    task automatic pairs(input bit a, input bit b, input int n, input bit rdy);
        for (int i = 0; i < n; i++) begin
            step(1'b1, a, rdy);
            step(1'b1, b, rdy);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        check("rst_word", word_out, 8'h00);
        check("rst_valid", word_valid, 1'b0);
        check("rst_fail", health_fail, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; raw_bit = 1'b0; word_ready = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        do_reset();

        // Basic extraction: 10,01 pairs pack to 0xAA, valid one cycle after the 16th sample.
        repeat (DISC) step(1'b1, 1'b1, 1'b1);
        pairs(1'b1, 1'b0, 1, 1'b1); pairs(1'b0, 1'b1, 1, 1'b1);
        pairs(1'b1, 1'b0, 1, 1'b1); pairs(1'b0, 1'b1, 1, 1'b1);
        pairs(1'b1, 1'b0, 1, 1'b1); pairs(1'b0, 1'b1, 1, 1'b1);
        pairs(1'b1, 1'b0, 1, 1'b1); pairs(1'b0, 1'b1, 1, 1'b1);
        check("lat_not_yet", word_valid, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("w1_valid", word_valid, 1'b1);
        check("w1_word", word_out, 8'hAA);
        check("model_w1", m_word, 8'hAA);
        check("w1_fail", health_fail, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("w1_consumed", word_valid, 1'b0);

        // Equal pairs only: no words, runs never exceed 2.
        repeat (DISC) step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            pairs(1'b0, 1'b0, 1, 1'b1);
            pairs(1'b1, 1'b1, 1, 1'b1);
        end
        check("eq_valid", word_valid, 1'b0);
        check("eq_fail", health_fail, 1'b0);
        step(1'b0, 1'b0, 1'b1);

        // Backpressure: two 0xFF words held, third word and 01 bits dropped.
        repeat (DISC) step(1'b1, 1'b1, 1'b0);
        pairs(1'b1, 1'b0, 3 * W, 1'b0);
        pairs(1'b0, 1'b1, W, 1'b0);
        check("bp_valid", word_valid, 1'b1);
        check("bp_word", word_out, 8'hFF);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("bb_valid", word_valid, 1'b1);
        check("bb_word", word_out, 8'hFF);
        step(1'b1, 1'b0, 1'b0);
        check("bb_hold", word_out, 8'hFF);
        step(1'b0, 1'b0, 1'b1);
        check("bp_drained", word_valid, 1'b0);

        // Enable drop after 5 extracted bits: partial word discarded, start-up discard repeats.
        repeat (DISC) step(1'b1, 1'b0, 1'b1);
        pairs(1'b0, 1'b1, 5, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        repeat (DISC) step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            pairs(1'b1, 1'b0, 1, 1'b1);
            pairs(1'b0, 1'b1, 1, 1'b1);
        end
        step(1'b1, 1'b0, 1'b1);
        check("en_valid", word_valid, 1'b1);
        check("en_word", word_out, 8'hAA);
        step(1'b0, 1'b0, 1'b1);

        // Reset with a word pending and a partial assembly.
        repeat (DISC) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            pairs(1'b1, 1'b0, 1, 1'b0);
            pairs(1'b0, 1'b1, 1, 1'b0);
        end
        step(1'b1, 1'b0, 1'b0);
        check("pre_rst_valid", word_valid, 1'b1);
        pairs(1'b1, 1'b0, 3, 1'b0);
        do_reset();

        // Constant ones: failure at the 32nd post-discard sample.
        repeat (DISC) step(1'b1, 1'b0, 1'b1);
        repeat (CUT - 1) step(1'b1, 1'b1, 1'b1);
        check("rct_before", health_fail, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("rct_fail", health_fail, 1'b1);
        check("model_fail", m_fail, 1'b1);
        check("rct_valid", word_valid, 1'b0);
        pairs(1'b1, 1'b0, 20, 1'b1);
        check("rct_no_words", word_valid, 1'b0);
        check("rct_sticky", health_fail, 1'b1);
        do_reset();

        // Failure with a word pending: word dropped on the edge after the failure.
        repeat (DISC) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            pairs(1'b1, 1'b0, 1, 1'b0);
            pairs(1'b0, 1'b1, 1, 1'b0);
        end
        repeat (CUT - 1) step(1'b1, 1'b0, 1'b0);
        check("pend_valid", word_valid, 1'b1);
        check("pend_word", word_out, 8'hAA);
        check("pend_no_fail", health_fail, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("pend_fail", health_fail, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        check("pend_dropped", word_valid, 1'b0);
        pairs(1'b1, 1'b0, 20, 1'b1);
        check("pend_sticky", health_fail, 1'b1);
        check("pend_no_words", word_valid, 1'b0);
        do_reset();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
